// File: rtl/axis_pattern_pkg.sv
// Shared definitions for the AXI4-Stream pattern source: FSM encoding and
// the all-lanes-valid keep constant.
package axis_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Wide enough for any practical tdata width; users slice off DATA_WIDTH/8 bits.
  localparam int unsigned MAX_KEEP_WIDTH = 128;
  localparam logic [MAX_KEEP_WIDTH-1:0] KEEP_ALL = '1;

endpackage

// File: rtl/axis_pattern_source.sv
// AXI4-Stream packet generator: on start, emits pkt_count packets of pkt_len
// beats carrying an incrementing pattern from seed, with gap idle cycles between packets.
module axis_pattern_source
  import axis_pattern_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    pkt_len,
  input  logic [15:0]             pkt_count,
  input  logic [GAP_WIDTH-1:0]    gap,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [1:0]              state
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = GAP_WIDTH'(1);
  localparam logic [15:0]           CNT_ONE  = 16'd1;
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

  state_t                 state_q, state_d;
  logic                   done_d;
  logic [LEN_WIDTH-1:0]   len_q, beat_q;
  logic [15:0]            count_q, pkt_q;
  logic [GAP_WIDTH-1:0]   gap_cfg_q, gap_q;

  logic cfg_zero, handshake, beat_last, pkt_last;

  assign cfg_zero  = (pkt_len == '0) || (pkt_count == '0);
  assign handshake = m_axis_tvalid && m_axis_tready;
  assign beat_last = (beat_q == len_q - LEN_ONE);
  assign pkt_last  = (pkt_q == count_q - CNT_ONE);
  assign state     = state_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_zero) done_d  = 1'b1;
          else          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake && beat_last) begin
          if (pkt_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (gap_cfg_q != '0) begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_ONE) state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: there is no storage array here, so every register is reset and a
      // reset mid-run leaves nothing stale behind.
      state_q       <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      len_q         <= '0;
      beat_q        <= '0;
      count_q       <= '0;
      pkt_q         <= '0;
      gap_cfg_q     <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      busy          <= (state_d != ST_IDLE);
      done          <= done_d;
      m_axis_tvalid <= (state_d == ST_SEND);
      m_axis_tkeep  <= (state_d == ST_SEND) ? KEEP_ALL[KEEP_WIDTH-1:0] : '0;

      unique case (state_q)
        ST_IDLE: begin
          if (start && !cfg_zero) begin
            len_q        <= pkt_len;
            count_q      <= pkt_count;
            gap_cfg_q    <= gap;
            m_axis_tdata <= seed;
            beat_q       <= '0;
            pkt_q        <= '0;
            m_axis_tlast <= (pkt_len == LEN_ONE);
          end
        end
        ST_SEND: begin
          if (handshake) begin
            // Data runs continuously across packet boundaries.
            m_axis_tdata <= m_axis_tdata + DATA_ONE;
            if (beat_last) begin
              beat_q       <= '0;
              pkt_q        <= pkt_q + CNT_ONE;
              gap_q        <= gap_cfg_q;
              m_axis_tlast <= (state_d == ST_SEND) && (len_q == LEN_ONE);
            end else begin
              beat_q       <= beat_q + LEN_ONE;
              m_axis_tlast <= (beat_q + LEN_ONE == len_q - LEN_ONE);
            end
          end
        end
        ST_GAP: begin
          gap_q <= gap_q - GAP_ONE;
          if (state_d == ST_SEND) m_axis_tlast <= (len_q == LEN_ONE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axis_pattern_source.md
# axis_pattern_source

AXI4-Stream packet generator that drives the S2MM (stream-to-memory) side of the AXI DMA loopback path, acting as the transmitting end of the stream interface. On a start pulse it emits a programmed number of packets of a programmed length. Data is an incrementing pattern from a seed, every beat has full tkeep, and tlast marks each packet's final beat. It serves as a deterministic traffic source for DMA bring-up and throughput measurement.

## Interface
Parameters:
- DATA_WIDTH, 32, tdata width; tkeep width is DATA_WIDTH/8.
- LEN_WIDTH, 16, width of the beats-per-packet field.
- GAP_WIDTH, 8, width of the idle-cycles-between-packets field.

Ports:
- clk  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- pkt_len  in  LEN_WIDTH  beats per packet; latched at start.
- pkt_count  in  16  packets per run; latched at start.
- gap  in  GAP_WIDTH  idle cycles between packets; latched at start.
- seed  in  DATA_WIDTH  first data value of the run; latched at start.
- busy  out  1  high from the cycle after an accepted start until the run completes.
- done  out  1  one-cycle pulse at run completion.
- m_axis_tdata  out  DATA_WIDTH  pattern data.
- m_axis_tkeep  out  DATA_WIDTH/8  all ones while tvalid is high; 0 otherwise.
- m_axis_tlast  out  1  high on the last beat of each packet.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- state  out  2  FSM state, for debug: IDLE=0, SEND=1, GAP=2.

## Operation
- All outputs are registered. Reset drives every output to 0 and sets the state to IDLE. Reset aborts any run in progress; no done pulse is issued for an aborted run.
- IDLE, start=1:
  - If pkt_len==0 or pkt_count==0: pulse done on the next cycle and stay in IDLE. busy stays low and no beats are sent.
  - Otherwise: latch the configuration, set data to seed, clear the beat and packet counters, and go to SEND.
- SEND: tvalid=1. tdata, tkeep and tlast are held stable until the handshake (tvalid && tready). On each handshake:
  - data increments by 1, wrapping mod 2^DATA_WIDTH. The count is continuous across packet boundaries.
  - The beat counter increments.
  - tlast = (beat counter == pkt_len-1).
- Handshake on the last beat of a packet:
  - If this was the last packet: go to IDLE, drop tvalid, pulse done, drop busy.
  - Else, if gap==0: the next packet starts immediately, with no bubble in tvalid.
  - Else: go to GAP with tvalid=0 and load the gap counter.
- GAP: waits exactly gap cycles with tvalid low, then returns to SEND.
- start is ignored while busy. Configuration inputs have no effect after they are latched.
- tvalid never deasserts without a handshake, except on reset.

## Timing
- start at cycle N: tvalid and busy go high at cycle N+1, with tdata=seed.
- With tready held high, the block sends one beat per cycle. A packet of L beats occupies L cycles.
- Gap timing: the last beat's handshake is at cycle M. tvalid is low for cycles M+1 through M+gap and high again at cycle M+gap+1.
- done goes high at the cycle after the final handshake, for exactly one cycle. busy goes low in the same cycle.
- Zero-length or zero-count start: done goes high at cycle N+1.
- pkt_len==1: tlast is high on every beat.

## Structure
- Shared package axis_pattern_pkg holds:
  - the state encoding constants (ST_IDLE, ST_SEND, ST_GAP);
  - the helper constant KEEP_ALL.
- No sub-module is required. The beat, packet and gap counters and the data register are implemented inline in a single always block.

## Test plan
- Single packet: pkt_len=4, pkt_count=1, gap=0, seed=0x100, tready=1.
  - Required: tdata 0x100..0x103 on consecutive cycles, tlast on 0x103 only, tkeep=0xF, done one cycle later.
- Backpressure: same configuration, tready toggled 1,0,0,1,... at random.
  - Required: tdata, tlast and tkeep stay stable while tready is low; no beat is lost or duplicated; the sequence is still 0x100..0x103.
- Multi-packet with gap: pkt_len=3, pkt_count=2, gap=2, seed=0, tready=1.
  - Required: beats 0,1,2(tlast), then 2 cycles with tvalid low, then 3,4,5(tlast), then done.
  - Repeat with gap=0. Required: 6 beats with no tvalid bubble and tlast on 2 and 5.
- Wrap and degenerate inputs:
  - seed=0xFFFFFFFE, pkt_len=4. Required: 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
  - pkt_count=0. Required: done at N+1, no tvalid.
- Reset mid-packet: assert reset after the 2nd handshake of a pkt_len=8 run.
  - Required: all outputs are 0 on the next cycle and no done pulse is issued.
  - A following start runs cleanly from seed.
- Start while busy: pulse start with different configuration during a run.
  - Required: it is ignored; the original run completes unchanged.
